request_conditioner: RTL

- Front end that produces the `sensor` and `walk` inputs consumed by the intersection light controller.
- Synchronises and debounces the raw pedestrian push-button and the raw vehicle detector.
- Holds each walk request as a level until the controller acknowledges it by raising `walk_light`.
- Drives the pedestrian "WAIT" lamp and flags requests left unserved for too long.

---
 rtl/request_conditioner_pkg.sv | 24 ++
 rtl/request_conditioner_sync_debounce.sv | 59 +++++
 rtl/request_conditioner.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/request_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : request_conditioner_pkg
// Purpose  : Shared definitions for the request conditioner front end. It holds
//            the walk FSM state encoding and the default debounce and timeout
//            constants, which the light controller's bench also uses.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package request_conditioner_pkg;

    // Walk request FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVING = 2'd2
    } walk_state_t;

    // Default tuning shared with the light controller's bench
    localparam int c_DEF_DEB_CYCLES = 4;
    localparam int c_DEF_TIMEOUT    = 40;

endpackage : request_conditioner_pkg
`default_nettype wire

// File: rtl/request_conditioner_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sync_debounce
// Purpose  : Two-flop synchroniser followed by a debounce filter. The stable
//            value only follows the synchronised input after DEB_CYCLES
//            consecutive disagreeing samples.
// Ports    : clk   - system clock
//            reset - asynchronous active-low reset
//            din   - raw asynchronous input
//            dout  - debounced stable level
// Revision : 1.0 - initial release
// ============================================================================
module sync_debounce
    import request_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES = c_DEF_DEB_CYCLES,
    parameter int DEB_W      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [DEB_W-1:0] c_CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [DEB_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_stable) begin
                // The count never exceeds c_CNT_LAST, so it cannot wrap.
                if (r_cnt == c_CNT_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + DEB_W'(1);
                end
            end else begin
                // Any agreeing sample restarts the run, rejecting short glitches.
                r_cnt <= '0;
            end
        end
    end

    assign dout = r_stable;

endmodule : sync_debounce
`default_nettype wire

// File: rtl/request_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : request_conditioner
// Purpose  : Conditions the raw pedestrian button and vehicle detector for the
//            intersection light controller. It holds walk requests until the
//            controller acknowledges them, drives the WAIT lamp and flags
//            starved requests.
// Ports    : clk        - system clock
//            reset      - asynchronous active-low reset
//            walk_btn   - raw pedestrian button (async, bouncy)
//            car_det    - raw vehicle detector (async, bouncy)
//            walk_light - controller walk lamp; a rising edge is the acknowledge
//            walk       - held walk request
//            sensor     - debounced vehicle-present level
//            wait_lamp  - pedestrian WAIT indicator
//            starve     - request pending for TIMEOUT cycles or more
// Revision : 1.0 - initial release
// ============================================================================
module request_conditioner
    import request_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES = c_DEF_DEB_CYCLES,
    parameter int DEB_W      = 4,
    parameter int TIMEOUT    = c_DEF_TIMEOUT,
    parameter int TO_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic walk_btn,
    input  logic car_det,
    input  logic walk_light,
    output logic walk,
    output logic sensor,
    output logic wait_lamp,
    output logic starve
);

    localparam logic [TO_W-1:0] c_TO_MAX = TO_W'(TIMEOUT);

    logic            w_btn_stable;
    logic            w_car_stable;
    logic            w_btn_rise;
    logic            w_wl_rise;
    logic            r_sensor;
    logic            r_btn_stable;
    logic            r_btn_stable_d;
    logic            r_walk_light_d;
    logic [TO_W-1:0] r_tcnt;
    walk_state_t     r_state;
    walk_state_t     w_state_next;

    sync_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_btn_deb (
        .clk   (clk),
        .reset (reset),
        .din   (walk_btn),
        .dout  (w_btn_stable)
    );

    sync_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_car_deb (
        .clk   (clk),
        .reset (reset),
        .din   (car_det),
        .dout  (w_car_stable)
    );

    // Both debounced levels are registered once more, so the button path
    // lines up with the sensor path before the edge detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sensor       <= 1'b0;
            r_btn_stable   <= 1'b0;
            r_btn_stable_d <= 1'b0;
            r_walk_light_d <= 1'b0;
        end else begin
            r_sensor       <= w_car_stable;
            r_btn_stable   <= w_btn_stable;
            r_btn_stable_d <= r_btn_stable;
            r_walk_light_d <= walk_light;
        end
    end

    assign w_btn_rise = r_btn_stable & ~r_btn_stable_d;
    assign w_wl_rise  = walk_light & ~r_walk_light_d;

    // Walk FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Walk FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // A walk phase the controller starts on its own beats a press.
                if (walk_light) begin
                    w_state_next = ST_SERVING;
                end else if (w_btn_rise) begin
                    w_state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // The acknowledge wins over a coincident press; nothing is queued.
                if (w_wl_rise) begin
                    w_state_next = ST_SERVING;
                end
            end
            ST_SERVING: begin
                // Presses here are absorbed by the phase in progress.
                if (!walk_light) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Timeout counter: runs only while pending and saturates at TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcnt <= '0;
        end else if (r_state != ST_PENDING) begin
            r_tcnt <= '0;
        end else if (r_tcnt != c_TO_MAX) begin
            r_tcnt <= r_tcnt + TO_W'(1);
        end
    end

    assign walk      = (r_state == ST_PENDING);
    assign wait_lamp = (r_state == ST_PENDING);
    assign starve    = (r_state == ST_PENDING) && (r_tcnt == c_TO_MAX);
    assign sensor    = r_sensor;

endmodule : request_conditioner
`default_nettype wire
